// File: rtl/rom_dl_writer.sv
// Queues hps_io ROM download words and writes them byte-swapped to ddram over a toggle req/ack handshake.
// Latency: at least 2 cycles per word plus ddram ack delay. Backpressure: ioctl_wait is raised one slot before the FIFO is full.
`timescale 1ns/1ps
module rom_dl_writer #(
    parameter int DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_data,
    output logic        ioctl_wait,
    output logic [24:0] wraddr,
    output logic [15:0] din,
    output logic        we_req,
    input  logic        we_ack,
    output logic [23:0] rom_size,
    output logic        done,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    state_t        state;
    logic          dl_q;
    logic          armed;

    logic          full;
    logic          push;
    logic          pop;
    logic          dl_rise;
    logic          dl_fall;
    logic [24:0]   size_cand;
    logic [23:0]   size_new;
    logic [23:0]   size_base;
    logic [39:0]   head;

    assign full      = (count == CW'(DEPTH));
    assign push      = ioctl_download & ioctl_wr & ~full;
    assign pop       = (state == BUSY) & (we_ack == we_req);
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign dl_rise   = ioctl_download & ~dl_q;
    assign dl_fall   = ~ioctl_download & dl_q;
    assign size_cand = {1'b0, ioctl_addr[24:1]} + 25'd1;
    assign size_new  = size_cand[24] ? 24'hFFFFFF : size_cand[23:0];
    // A push on the same cycle as a new download compares against a cleared size.
    assign size_base = dl_rise ? 24'd0 : rom_size;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr] <= {ioctl_addr[24:1], ioctl_data};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            dl_q       <= 1'b0;
            armed      <= 1'b0;
            ioctl_wait <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            rom_size   <= '0;
            wraddr     <= '0;
            din        <= '0;
            // Resync so an abandoned transaction never looks pending.
            we_req     <= we_ack;
        end else begin
            dl_q <= ioctl_download;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count      <= count_nxt;
            ioctl_wait <= (count_nxt >= CW'(DEPTH - 1));
            overflow   <= (overflow & ~dl_rise) | (ioctl_download & ioctl_wr & full);

            if (push && (size_new > size_base)) begin
                rom_size <= size_new;
            end else if (dl_rise) begin
                rom_size <= '0;
            end

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        wraddr <= {head[39:16], 1'b0};
                        din    <= {head[7:0], head[15:8]};
                        we_req <= ~we_req;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (we_ack == we_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            done <= 1'b0;
            if (dl_rise) begin
                armed <= 1'b0;
            end else if (dl_fall) begin
                armed <= 1'b1;
            end else if (armed && (count == '0) && (state == IDLE)) begin
                done  <= 1'b1;
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_dl_writer.sv
// Bench for rom_dl_writer: directed scenarios plus randomized downloads checked against an in-order word model.
`timescale 1ns/1ps
module tb_rom_dl_writer;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_data;
    logic        ioctl_wait;
    logic [24:0] wraddr;
    logic [15:0] din;
    logic        we_req;
    logic        we_ack;
    logic [23:0] rom_size;
    logic        done;
    logic        overflow;

    always #5 clk_sys = ~clk_sys;

    rom_dl_writer #(.DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wait(ioctl_wait), .wraddr(wraddr), .din(din), .we_req(we_req),
        .we_ack(we_ack), .rom_size(rom_size), .done(done), .overflow(overflow)
    );

    int          checks = 0;
    int          failures = 0;
    logic [40:0] exp_q[$];
    logic [40:0] got_q[$];
    logic [40:0] cur_req = '0;
    logic        prev_req = 1'bx;
    int          done_cnt = 0;
    int          n_req = 0;
    bit          ack_en = 1'b1;
    int          ack_dly = 0;
    int          ack_cnt = 0;
    longint      max_word = -1;

    task automatic chk(input string tag, input logic [40:0] obs, input logic [40:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] swap16(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

    // ddram model: records each request, checks it holds steady, acks after ack_dly extra cycles.
    always @(negedge clk_sys) begin
        if (reset_n === 1'b1 && !$isunknown(prev_req) && we_req !== prev_req) begin
            n_req++;
            cur_req = {wraddr, din};
            got_q.push_back(cur_req);
        end else if (reset_n === 1'b1 && we_req !== we_ack) begin
            chk("stable", {wraddr, din}, cur_req);
        end
        prev_req = we_req;
        if (done === 1'b1) done_cnt++;
        if (ack_en && reset_n === 1'b1 && we_req !== we_ack) begin
            if (ack_cnt >= ack_dly) begin
                we_ack  = we_req;
                ack_cnt = 0;
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    task automatic begin_dl();
        exp_q.delete();
        got_q.delete();
        done_cnt = 0;
        max_word = -1;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic wr_word(input logic [24:0] a, input logic [15:0] d, input logic [15:0] expd,
                           input bit obey_wait, input bit accepted);
        int n = 0;
        while (obey_wait && ioctl_wait === 1'b1 && n < 500) begin
            @(negedge clk_sys);
            n++;
        end
        chk("wait_release", 41'(n >= 500), 41'd0);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_data = d;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        if (accepted) begin
            exp_q.push_back({a[24:1], 1'b0, expd});
            if (longint'(a[24:1]) > max_word) max_word = longint'(a[24:1]);
        end
    endtask

    task automatic end_dl(input string tag, input logic exp_ovf);
        int     n = 0;
        longint er;
        ioctl_download = 1'b0;
        while (!(got_q.size() >= exp_q.size() && done_cnt > 0) && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        chk({tag, "_drain"}, 41'(n >= 2000), 41'd0);
        repeat (5) @(negedge clk_sys);
        chk({tag, "_nwords"}, 41'(got_q.size()), 41'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_word"}, got_q[i], exp_q[i]);
        chk({tag, "_done_once"}, 41'(done_cnt), 41'd1);
        er = (max_word + 1 > 64'hFFFFFF) ? 64'hFFFFFF : max_word + 1;
        chk({tag, "_rom_size"}, 41'(rom_size), 41'(er));
        chk({tag, "_overflow"}, 41'(overflow), 41'(exp_ovf));
    endtask

    initial begin
        logic [15:0] d;
        logic [24:0] a;
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_data = '0; we_ack = 1'b1;

        // Reset with we_ack high: we_req follows it and nothing is issued.
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("rst_we_req", 41'(we_req), 41'd1);
        chk("rst_wait", 41'(ioctl_wait), 41'd0);
        chk("rst_done", 41'(done), 41'd0);
        chk("rst_ovf", 41'(overflow), 41'd0);
        chk("rst_rom_size", 41'(rom_size), 41'd0);
        chk("rst_out", {wraddr, din}, 41'd0);
        n_req = 0;
        repeat (10) @(negedge clk_sys);
        chk("rst_no_write", 41'(n_req), 41'd0);

        // Three words, ack one cycle after req.
        ack_dly = 0;
        begin_dl();
        wr_word(25'h0, 16'h1234, 16'h3412, 1, 1);
        wr_word(25'h2, 16'h5678, 16'h7856, 1, 1);
        wr_word(25'h4, 16'h9ABC, 16'hBC9A, 1, 1);
        end_dl("three", 1'b0);
        chk("three_size_lit", 41'(rom_size), 41'd3);

        // Ack held off: wait rises at count 3, slot 4 still fills, fifth strobe is dropped.
        ack_en = 1'b0;
        begin_dl();
        wr_word(25'h10, 16'hA001, 16'h01A0, 0, 1);
        wr_word(25'h12, 16'hA002, 16'h02A0, 0, 1);
        chk("bp_wait_lo", 41'(ioctl_wait), 41'd0);
        wr_word(25'h14, 16'hA003, 16'h03A0, 0, 1);
        chk("bp_wait_hi", 41'(ioctl_wait), 41'd1);
        wr_word(25'h16, 16'hA004, 16'h04A0, 0, 1);
        chk("bp_ovf_lo", 41'(overflow), 41'd0);
        wr_word(25'h40, 16'hA005, 16'h05A0, 0, 0);
        chk("bp_ovf_hi", 41'(overflow), 41'd1);
        repeat (50) @(negedge clk_sys);
        ack_en = 1'b1;
        end_dl("bp", 1'b1);

        // New download clears overflow and size; out-of-order addresses.
        begin_dl();
        chk("rise_ovf_clr", 41'(overflow), 41'd0);
        chk("rise_size_clr", 41'(rom_size), 41'd0);
        d = 16'($urandom);
        wr_word(25'h100, d, swap16(d), 1, 1);
        d = 16'($urandom);
        wr_word(25'h002, d, swap16(d), 1, 1);
        end_dl("ooo", 1'b0);
        chk("ooo_size_lit", 41'(rom_size), 41'h81);

        // Top of the address space saturates the size.
        begin_dl();
        d = 16'($urandom);
        wr_word(25'h1FFFFFE, d, swap16(d), 1, 1);
        end_dl("sat", 1'b0);
        chk("sat_size_lit", 41'(rom_size), 41'hFFFFFF);

        // Random downloads with varied ack latency and strobe gaps (push/pop overlap occurs here).
        for (int r = 0; r < 3; r++) begin
            begin_dl();
            for (int i = 0; i < 40; i++) begin
                ack_dly = $urandom_range(0, 3);
                repeat ($urandom_range(0, 2)) @(negedge clk_sys);
                a = 25'($urandom_range(0, 4095)) << 1;
                d = 16'($urandom);
                wr_word(a, d, swap16(d), 1, 1);
            end
            end_dl("rand", 1'b0);
        end

        // Reset while busy with words queued: everything is abandoned.
        ack_dly = 0;
        ack_en = 1'b0;
        begin_dl();
        wr_word(25'h20, 16'h1111, 16'h1111, 1, 1);
        wr_word(25'h22, 16'h2222, 16'h2222, 1, 1);
        wr_word(25'h24, 16'h3333, 16'h3333, 1, 1);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        done_cnt = 0;
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        ack_en = 1'b1;
        @(negedge clk_sys);
        n_req = 0;
        repeat (20) @(negedge clk_sys);
        chk("midrst_no_req", 41'(n_req), 41'd0);
        chk("midrst_no_done", 41'(done_cnt), 41'd0);
        chk("midrst_synced", 41'(we_req), 41'(we_ack));
        chk("midrst_wait", 41'(ioctl_wait), 41'd0);
        begin_dl();
        d = 16'($urandom);
        wr_word(25'h30, d, swap16(d), 1, 1);
        end_dl("post_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
